// File: rtl/avalon_st_packet_channel_arbiter_pkg.sv
// Shared types and helpers for the packet-level Avalon-ST channel arbiter.
// Imported by the arbiter top and its round-robin picker.
package avalon_st_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arbState_t;

  localparam int DEFAULT_NUM_IN    = 4;
  localparam int DEFAULT_DATA_W    = 8;
  localparam int DEFAULT_CHANNEL_W = 8;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/avalon_st_packet_channel_arbiter_if.sv
// Bundle of the NUM_IN source streams, the merged channelized output and busy.
// The arbiter uses the master modport; the sources/sink side uses slave.
interface avalon_st_packet_channel_arbiter_if #(
  parameter int NUM_IN    = 4,
  parameter int DATA_W    = 8,
  parameter int CHANNEL_W = 8
);
  logic [NUM_IN-1:0]        in_valid;
  logic [NUM_IN*DATA_W-1:0] in_data;
  logic [NUM_IN-1:0]        in_startofpacket;
  logic [NUM_IN-1:0]        in_endofpacket;
  logic [NUM_IN-1:0]        in_ready;
  logic                     out_ready;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_data;
  logic                     out_startofpacket;
  logic                     out_endofpacket;
  logic [CHANNEL_W-1:0]     out_channel;
  logic                     busy;

  modport master (
    input  in_valid, in_data, in_startofpacket, in_endofpacket, out_ready,
    output in_ready, out_valid, out_data, out_startofpacket, out_endofpacket,
           out_channel, busy
  );

  modport slave (
    output in_valid, in_data, in_startofpacket, in_endofpacket, out_ready,
    input  in_ready, out_valid, out_data, out_startofpacket, out_endofpacket,
           out_channel, busy
  );
endinterface

// File: rtl/avalon_st_packet_channel_arbiter_picker.sv
// Combinational round-robin picker: first set request bit scanning from ptr_i
// upward, wrapping modulo NUM_IN.
module rr_priority_picker
  import avalon_st_arb_pkg::*;
#(
  parameter int NUM_IN = DEFAULT_NUM_IN,
  localparam int IDX_W = clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req_i,
  input  logic [IDX_W-1:0]  ptr_i,
  output logic [IDX_W-1:0]  idx_o,
  output logic              any_o
);

  logic [IDX_W-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int off = NUM_IN - 1; off >= 0; off--) begin
      cand = IDX_W'((int'(ptr_i) + off) % NUM_IN);
      if (req_i[cand]) begin
        idx_o = cand;
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/avalon_st_packet_channel_arbiter.sv
// Merges NUM_IN packetized Avalon-ST sources into one channelized stream,
// granting round-robin and holding the grant for a whole packet.
module avalon_st_packet_channel_arbiter
  import avalon_st_arb_pkg::*;
#(
  parameter int NUM_IN    = DEFAULT_NUM_IN,
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int CHANNEL_W = DEFAULT_CHANNEL_W
) (
  input logic clk,
  input logic reset,
  avalon_st_packet_channel_arbiter_if.master bus
);

  localparam int IDX_W = clog2(NUM_IN);

  if (NUM_IN < 2 || NUM_IN > 16) begin : gBadNumIn
    $error("NUM_IN must be within 2..16");
  end
  if (CHANNEL_W < IDX_W) begin : gBadChannelW
    $error("CHANNEL_W must be at least clog2(NUM_IN)");
  end

  arbState_t            state_q, state_d;
  logic [IDX_W-1:0]     grantIdx_q, grantIdx_d;
  logic [IDX_W-1:0]     rrPtr_q, rrPtr_d;
  logic [IDX_W-1:0]     pickIdx;
  logic                 pickAny;
  logic                 slotFree;
  logic                 accept;
  logic                 acceptEop;
  logic [DATA_W-1:0]    inData [NUM_IN];
  logic                 outValid_q, outSop_q, outEop_q;
  logic [DATA_W-1:0]    outData_q;
  logic [CHANNEL_W-1:0] outChannel_q;

  for (genvar i = 0; i < NUM_IN; i++) begin : gUnpack
    assign inData[i] = bus.in_data[i*DATA_W +: DATA_W];
  end

  rr_priority_picker #(.NUM_IN(NUM_IN)) uPicker (
    .req_i (bus.in_valid),
    .ptr_i (rrPtr_q),
    .idx_o (pickIdx),
    .any_o (pickAny)
  );

  // Ready is derived from state and the output slot only, never from in_valid.
  assign slotFree  = !outValid_q || bus.out_ready;
  assign accept    = (state_q == LOCKED) && slotFree && bus.in_valid[grantIdx_q];
  assign acceptEop = accept && bus.in_endofpacket[grantIdx_q];

  always_comb begin
    state_d      = state_q;
    grantIdx_d   = grantIdx_q;
    rrPtr_d      = rrPtr_q;
    bus.in_ready = '0;
    unique case (state_q)
      IDLE: begin
        if (pickAny) begin
          grantIdx_d = pickIdx;
          state_d    = LOCKED;
        end
      end
      LOCKED: begin
        bus.in_ready[grantIdx_q] = slotFree;
        if (acceptEop) begin
          state_d = IDLE;
          rrPtr_d = (grantIdx_q == IDX_W'(NUM_IN - 1)) ? '0 : grantIdx_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      grantIdx_q <= '0;
      rrPtr_q    <= '0;
    end else begin
      state_q    <= state_d;
      grantIdx_q <= grantIdx_d;
      rrPtr_q    <= rrPtr_d;
    end
  end

  // Output slot refills on any accepted beat, even while draining.
  always_ff @(posedge clk) begin
    if (reset) begin
      outValid_q   <= 1'b0;
      outSop_q     <= 1'b0;
      outEop_q     <= 1'b0;
      outData_q    <= '0;
      outChannel_q <= '0;
    end else if (accept) begin
      outValid_q   <= 1'b1;
      outSop_q     <= bus.in_startofpacket[grantIdx_q];
      outEop_q     <= bus.in_endofpacket[grantIdx_q];
      outData_q    <= inData[grantIdx_q];
      outChannel_q <= CHANNEL_W'(grantIdx_q);
    end else if (bus.out_ready) begin
      outValid_q   <= 1'b0;
    end
  end

  assign bus.out_valid         = outValid_q;
  assign bus.out_data          = outData_q;
  assign bus.out_startofpacket = outSop_q;
  assign bus.out_endofpacket   = outEop_q;
  assign bus.out_channel       = outChannel_q;
  assign bus.busy              = (state_q == LOCKED);

endmodule

// File: tb/tb_avalon_st_packet_channel_arbiter.sv
// Self-checking bench: sources replay generated packets, a sink scoreboard
// checks every channel's stream arrives intact, plus directed timing checks.
module tb_avalon_st_packet_channel_arbiter;

  localparam int NUM_IN    = 4;
  localparam int DATA_W    = 8;
  localparam int CHANNEL_W = 8;

  typedef struct packed {
    logic              sop;
    logic              eop;
    logic [DATA_W-1:0] data;
  } beat_t;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  avalon_st_packet_channel_arbiter_if #(
    .NUM_IN(NUM_IN), .DATA_W(DATA_W), .CHANNEL_W(CHANNEL_W)
  ) bus ();

  avalon_st_packet_channel_arbiter #(
    .NUM_IN(NUM_IN), .DATA_W(DATA_W), .CHANNEL_W(CHANNEL_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  beat_t             genQ [NUM_IN][$];
  beat_t             rxQ  [NUM_IN][$];
  int                rxChanLog[$];
  int                sendIdx [NUM_IN];
  logic [NUM_IN-1:0] accPrev;
  logic [NUM_IN-1:0] srcEn;
  logic              sinkReady;
  int                cycleNo;
  int                readyViolations;
  int                interleaveErrs;
  logic              rxInPkt;
  int                rxChan;
  int                rrExp;
  int                testsRun = 0;
  int                testsFailed = 0;

  task automatic clearTraffic();
    for (int s = 0; s < NUM_IN; s++) begin
      genQ[s].delete();
      rxQ[s].delete();
      sendIdx[s] = 0;
    end
    rxChanLog.delete();
    accPrev         = '0;
    srcEn           = '0;
    readyViolations = 0;
    interleaveErrs  = 0;
    rxInPkt         = 1'b0;
    rxChan          = 0;
  endtask

  task automatic addPacket(input int s, input int len, input int base, input bit randData);
    for (int k = 0; k < len; k++) begin
      beat_t b;
      b.sop  = (k == 0);
      b.eop  = (k == len - 1);
      b.data = randData ? DATA_W'($urandom) : DATA_W'(base + k);
      genQ[s].push_back(b);
    end
  endtask

  function automatic bit streamIntact(input int s);
    if (rxQ[s].size() != genQ[s].size()) return 1'b0;
    for (int k = 0; k < genQ[s].size(); k++)
      if (rxQ[s][k] !== genQ[s][k]) return 1'b0;
    return 1'b1;
  endfunction

  // One clock: sources present their next beat, sink records any transfer.
  task automatic applyStimulus();
    logic [NUM_IN*DATA_W-1:0] data;
    @(posedge clk);
    #1;
    for (int s = 0; s < NUM_IN; s++) if (accPrev[s]) sendIdx[s]++;
    bus.in_valid         = '0;
    bus.in_startofpacket = '0;
    bus.in_endofpacket   = '0;
    data                 = '0;
    for (int s = 0; s < NUM_IN; s++) begin
      if (sendIdx[s] < genQ[s].size()) begin
        data[s*DATA_W +: DATA_W] = genQ[s][sendIdx[s]].data;
        bus.in_startofpacket[s]  = genQ[s][sendIdx[s]].sop;
        bus.in_endofpacket[s]    = genQ[s][sendIdx[s]].eop;
        bus.in_valid[s]          = srcEn[s];
      end
    end
    bus.in_data   = data;
    bus.out_ready = sinkReady;
    @(negedge clk);
    cycleNo++;
    accPrev = bus.in_valid & bus.in_ready;
    if ($countones(bus.in_ready) > 1) readyViolations++;
    if (bus.out_valid && bus.out_ready) begin
      if (bus.out_startofpacket) begin
        if (rxInPkt) interleaveErrs++;
        rxChanLog.push_back(int'(bus.out_channel));
      end else if (!rxInPkt || int'(bus.out_channel) != rxChan) begin
        interleaveErrs++;
      end
      rxInPkt = !bus.out_endofpacket;
      rxChan  = int'(bus.out_channel);
      if (bus.out_channel < CHANNEL_W'(NUM_IN))
        rxQ[int'(bus.out_channel)].push_back({bus.out_startofpacket, bus.out_endofpacket, bus.out_data});
      else
        interleaveErrs++;
    end
  endtask

  task automatic test_reset();
    bit ok;
    clearTraffic();
    for (int s = 0; s < NUM_IN; s++) addPacket(s, 1, 'h10 + s, 1'b0);
    srcEn     = '1;
    sinkReady = 1'b1;
    reset     = 1'b1;
    repeat (3) applyStimulus();
    testsRun++;
    if (bus.in_ready !== 4'b0000) begin testsFailed++; $display("[TB] FAIL reset_in_ready: got %b want 0000", bus.in_ready); end
    testsRun++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_valid_busy: got %b%b want 00", bus.out_valid, bus.busy); end
    testsRun++;
    if (bus.out_channel !== '0) begin testsFailed++; $display("[TB] FAIL reset_channel: got %0d want 0", bus.out_channel); end
    reset = 1'b0;
    applyStimulus();
    testsRun++;
    if (bus.in_ready !== 4'b0001) begin testsFailed++; $display("[TB] FAIL reset_first_grant: got %b want 0001", bus.in_ready); end
    applyStimulus();
    testsRun++;
    if ({bus.out_valid, bus.out_channel, bus.out_data} !== {1'b1, CHANNEL_W'(0), DATA_W'('h10)}) begin
      testsFailed++; $display("[TB] FAIL reset_first_beat: got v=%b ch=%0d d=%h want v=1 ch=0 d=10", bus.out_valid, bus.out_channel, bus.out_data);
    end
    repeat (8) applyStimulus();
    ok = (rxChanLog.size() == NUM_IN);
    for (int k = 0; ok && k < NUM_IN; k++) ok = (rxChanLog[k] == k);
    testsRun++;
    if (!ok) begin testsFailed++; $display("[TB] FAIL reset_rr_order: got %0d packets want order 0,1,2,3", rxChanLog.size()); end
    rrExp = 0;
  endtask

  task automatic test_single_packet();
    logic [18:0] got, want;
    clearTraffic();
    addPacket(2, 3, 'hA1, 1'b0);
    srcEn     = 4'b0100;
    sinkReady = 1'b1;
    applyStimulus();
    testsRun++;
    if (bus.out_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL single_no_early_valid: got %b want 0", bus.out_valid); end
    applyStimulus();
    testsRun++;
    if (bus.in_ready !== 4'b0100) begin testsFailed++; $display("[TB] FAIL single_grant: got %b want 0100", bus.in_ready); end
    for (int k = 0; k < 3; k++) begin
      applyStimulus();
      got  = {bus.out_valid, bus.out_startofpacket, bus.out_endofpacket, bus.out_channel, bus.out_data};
      want = {1'b1, (k == 0), (k == 2), CHANNEL_W'(2), DATA_W'('hA1 + k)};
      testsRun++;
      if (got !== want) begin testsFailed++; $display("[TB] FAIL single_beat%0d: got %h want %h", k, got, want); end
    end
    applyStimulus();
    testsRun++;
    if (bus.out_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL single_drain: got %b want 0", bus.out_valid); end
    rrExp = 3;
  endtask

  task automatic test_round_robin();
    int  validCycles[$];
    bit  ok;
    clearTraffic();
    for (int s = 0; s < NUM_IN; s++)
      for (int k = 0; k < 4; k++) addPacket(s, 1, s * 16 + k, 1'b0);
    srcEn     = '1;
    sinkReady = 1'b1;
    repeat (40) begin
      applyStimulus();
      if (bus.out_valid) validCycles.push_back(cycleNo);
    end
    ok = (rxChanLog.size() == 16);
    for (int k = 0; ok && k < 16; k++) ok = (rxChanLog[k] == (rrExp + k) % NUM_IN);
    testsRun++;
    if (!ok) begin testsFailed++; $display("[TB] FAIL rr_sequence: got %0d packets want 16 starting at ch %0d", rxChanLog.size(), rrExp); end
    ok = (validCycles.size() == 16);
    for (int k = 1; ok && k < validCycles.size(); k++) ok = (validCycles[k] - validCycles[k-1] == 2);
    testsRun++;
    if (!ok) begin testsFailed++; $display("[TB] FAIL rr_throughput: got %0d valid cycles want 16 spaced by 2", validCycles.size()); end
    for (int s = 0; s < NUM_IN; s++) begin
      testsRun++;
      if (!streamIntact(s)) begin testsFailed++; $display("[TB] FAIL rr_stream%0d: got %0d beats want %0d", s, rxQ[s].size(), genQ[s].size()); end
    end
  endtask

  task automatic test_back_pressure();
    logic [DATA_W-1:0] expHeld;
    clearTraffic();
    addPacket(0, 4, 'hB0, 1'b0);
    srcEn = 4'b0001;
    for (int i = 1; i <= 16; i++) begin
      sinkReady = !(i >= 4 && i <= 8);
      applyStimulus();
      if (!sinkReady && bus.out_valid) begin
        expHeld = (rxQ[0].size() < genQ[0].size()) ? genQ[0][rxQ[0].size()].data : '0;
        testsRun++;
        if (bus.out_data !== expHeld) begin testsFailed++; $display("[TB] FAIL bp_hold_c%0d: got %h want %h", i, bus.out_data, expHeld); end
        testsRun++;
        if (bus.in_ready !== 4'b0000) begin testsFailed++; $display("[TB] FAIL bp_no_accept_c%0d: got %b want 0000", i, bus.in_ready); end
      end
    end
    sinkReady = 1'b1;
    testsRun++;
    if (!streamIntact(0)) begin testsFailed++; $display("[TB] FAIL bp_stream: got %0d beats want %0d", rxQ[0].size(), genQ[0].size()); end
    testsRun++;
    if (rxChanLog.size() != 1) begin testsFailed++; $display("[TB] FAIL bp_packets: got %0d want 1", rxChanLog.size()); end
    rrExp = 1;
  endtask

  task automatic test_drop_valid();
    clearTraffic();
    addPacket(1, 5, 'hC0, 1'b0);
    addPacket(3, 1, 'hD0, 1'b0);
    sinkReady = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      srcEn = {1'b1, 1'b0, !(i >= 5 && i <= 8), 1'b0};
      applyStimulus();
      if (i >= 5 && i <= 8) begin
        testsRun++;
        if ({bus.busy, bus.in_ready} !== 5'b10010) begin testsFailed++; $display("[TB] FAIL drop_lock_c%0d: got busy=%b rdy=%b want busy=1 rdy=0010", i, bus.busy, bus.in_ready); end
      end
    end
    testsRun++;
    if (rxChanLog.size() != 2 || rxChanLog[0] != 1 || rxChanLog[1] != 3) begin
      testsFailed++; $display("[TB] FAIL drop_order: got %0d packets want channels 1 then 3", rxChanLog.size());
    end
    testsRun++;
    if (!streamIntact(1) || !streamIntact(3)) begin testsFailed++; $display("[TB] FAIL drop_streams: got %0d/%0d beats want 5/1", rxQ[1].size(), rxQ[3].size()); end
    rrExp = 0;
  endtask

  task automatic test_reset_locked();
    int guard;
    clearTraffic();
    addPacket(2, 1, 'hE0, 1'b0);
    addPacket(2, 6, 'hE1, 1'b0);
    srcEn     = 4'b0100;
    sinkReady = 1'b1;
    guard     = 0;
    while (sendIdx[2] < 3 && guard < 30) begin
      applyStimulus();
      guard++;
    end
    testsRun++;
    if (sendIdx[2] < 3 || bus.busy !== 1'b1) begin testsFailed++; $display("[TB] FAIL rl_mid_packet: got beats=%0d busy=%b want beats=3 busy=1", sendIdx[2], bus.busy); end
    srcEn = '0;
    reset = 1'b1;
    applyStimulus();
    testsRun++;
    if ({bus.out_valid, bus.out_startofpacket, bus.out_endofpacket, bus.out_data, bus.out_channel, bus.in_ready, bus.busy} !== '0) begin
      testsFailed++; $display("[TB] FAIL rl_cleared: got v=%b d=%h ch=%0d rdy=%b busy=%b want all 0", bus.out_valid, bus.out_data, bus.out_channel, bus.in_ready, bus.busy);
    end
    reset = 1'b0;
    clearTraffic();
    addPacket(1, 1, 'hF1, 1'b0);
    addPacket(3, 1, 'hF3, 1'b0);
    srcEn = 4'b1010;
    repeat (10) applyStimulus();
    testsRun++;
    if (rxChanLog.size() != 2 || rxChanLog[0] != 1 || rxChanLog[1] != 3) begin
      testsFailed++; $display("[TB] FAIL rl_rr_restart: got %0d packets first ch %0d want 1 then 3", rxChanLog.size(), (rxChanLog.size() > 0) ? rxChanLog[0] : -1);
    end
    rrExp = 0;
  endtask

  task automatic test_random();
    int  totalPkts;
    bit  done;
    int  guard;
    clearTraffic();
    totalPkts = 0;
    for (int s = 0; s < NUM_IN; s++) begin
      int n = $urandom_range(3, 6);
      for (int p = 0; p < n; p++) addPacket(s, $urandom_range(1, 5), 0, 1'b1);
      totalPkts += n;
    end
    done  = 1'b0;
    guard = 0;
    while (!done && guard < 3000) begin
      for (int s = 0; s < NUM_IN; s++) srcEn[s] = ($urandom_range(0, 3) != 0);
      sinkReady = ($urandom_range(0, 3) != 0);
      applyStimulus();
      guard++;
      done = 1'b1;
      for (int s = 0; s < NUM_IN; s++) if (rxQ[s].size() < genQ[s].size()) done = 1'b0;
    end
    sinkReady = 1'b1;
    testsRun++;
    if (!done) begin testsFailed++; $display("[TB] FAIL rand_complete: got timeout after %0d cycles want all packets delivered", guard); end
    testsRun++;
    if (rxChanLog.size() != totalPkts) begin testsFailed++; $display("[TB] FAIL rand_packets: got %0d want %0d", rxChanLog.size(), totalPkts); end
    testsRun++;
    if (readyViolations != 0 || interleaveErrs != 0) begin testsFailed++; $display("[TB] FAIL rand_protocol: got %0d ready/%0d interleave errors want 0", readyViolations, interleaveErrs); end
    for (int s = 0; s < NUM_IN; s++) begin
      testsRun++;
      if (!streamIntact(s)) begin testsFailed++; $display("[TB] FAIL rand_stream%0d: got %0d beats want %0d", s, rxQ[s].size(), genQ[s].size()); end
    end
  endtask

  initial begin
    reset                = 1'b1;
    bus.in_valid         = '0;
    bus.in_data          = '0;
    bus.in_startofpacket = '0;
    bus.in_endofpacket   = '0;
    bus.out_ready        = 1'b1;
    sinkReady            = 1'b1;
    cycleNo              = 0;
    rrExp                = 0;
    clearTraffic();
    test_reset();
    test_single_packet();
    test_round_robin();
    test_back_pressure();
    test_drop_valid();
    test_reset_locked();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got no completion want finish before time limit");
    $fatal(1, "[TB] time limit reached");
  end

endmodule
